program_loader: RTL and testbench

Streams a TIS-100 program into a node's instruction memory over a byte-wide valid/ready link. It packs each group of 3 bytes into one 21-bit op code in the layout the node's decoder consumes: op[20:17], src[16:14], const[13:3], dst[2:0]. It validates each word, writes it to program memory, and reports the program length. The node core is held idle while `busy` is high.

---
 rtl/program_loader_pkg.sv | 28 ++
 rtl/program_loader_word_assembler.sv | 34 +++
 rtl/program_loader.sv | 188 ++++++++++++++++++
 tb/tb_program_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for program_loader: state encodings, error codes, defaults.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM state).
package program_loader_pkg;

  localparam int unsigned MAX_INSTR_DEF = 15;

  // op/src bits live in byte0[4:0]; the top three bits must be zero
  localparam logic [7:0] BYTE0_RSVD_MASK = 8'hE0;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_BAD_COUNT = 2'd1;
  localparam logic [1:0] ERR_BAD_WORD  = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM  = 2'd3;

  typedef enum logic [2:0] {
`ifdef LOADER_CHECKSUM_EN
    ST_CSUM  = 3'd7,
`endif
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_B0    = 3'd2,
    ST_B1    = 3'd3,
    ST_B2    = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects the first two bytes of a word and presents the 21-bit op code
// together with the live third byte; flags illegal byte0 values.
module word_assembler
  import program_loader_pkg::*;
#(
  parameter int unsigned NUM_OPS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_i,
  input  logic        acc_i,
  input  logic        clr_i,
  output logic [20:0] word_o,
  output logic        bad_o
);

  logic [12:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (clr_i)      sh_d = '0;
    else if (acc_i) sh_d = {sh_q[4:0], byte_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= sh_d;
  end

  // after two accepts sh_q = {byte0[4:0], byte1}; the third byte is appended live
  assign word_o = {sh_q, byte_i};
  assign bad_o  = (|(byte_i & BYTE0_RSVD_MASK)) || (32'(byte_i[4:1]) >= NUM_OPS);

endmodule

// File: rtl/program_loader.sv
// Streams count + 3-byte words into node program memory, validating as it goes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MAX_INSTR = MAX_INSTR_DEF,
  parameter int unsigned NUM_OPS   = 16,
  parameter int unsigned AW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [20:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [AW-1:0] prog_len
);

  // one extra bit so a full memory (N == 2^AW) still compares correctly
  localparam int unsigned IW = AW + 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, n_q, n_d;
  logic [1:0]      code_q, code_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [20:0]     wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic            accept, asm_acc, asm_clr, asm_bad;
  logic [20:0]     asm_word;

  word_assembler #(.NUM_OPS(NUM_OPS)) u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .byte_i (in_data),
    .acc_i  (asm_acc),
    .clr_i  (asm_clr),
    .word_o (asm_word),
    .bad_o  (asm_bad)
  );

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    code_d  = code_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_acc = 1'b0;
    asm_clr = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (accept) csum_d = csum_q ^ in_data;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_COUNT;
          code_d  = ERR_NONE;
          idx_d   = '0;
          asm_clr = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_COUNT: begin
        if (accept) begin
          if (in_data == 8'd0 || 32'(in_data) > MAX_INSTR) begin
            state_d = ST_ERR;
            code_d  = ERR_BAD_COUNT;
          end else begin
            n_d     = IW'(in_data);
            state_d = ST_B0;
          end
        end
      end
      ST_B0: begin
        if (accept) begin
          if (asm_bad) begin
            state_d = ST_ERR;
            code_d  = ERR_BAD_WORD;
          end else begin
            asm_acc = 1'b1;
            state_d = ST_B1;
          end
        end
      end
      ST_B1: begin
        if (accept) begin
          asm_acc = 1'b1;
          state_d = ST_B2;
        end
      end
      ST_B2: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = idx_q[AW-1:0];
          wdata_d = asm_word;
          idx_d   = idx_q + IW'(1);
          asm_clr = 1'b1;
          if (idx_q + IW'(1) == n_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_B0;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
            code_d  = ERR_CHECKSUM;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      code_q  <= ERR_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      code_q  <= code_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_COUNT, ST_B0, ST_B1, ST_B2: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM: in_ready = 1'b1;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  assign busy      = in_ready;
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);
  assign err_code  = code_q;
  assign prog_len  = done ? n_q[AW-1:0] : '0;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a stream-parsing reference model.
// Honours LOADER_CHECKSUM_EN when the design is built with it.
module tb_program_loader;

  localparam int unsigned MAX_INSTR = 15;
  localparam int unsigned NUM_OPS   = 16;
  localparam int unsigned AW        = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_we, busy, done, error;
  logic [AW-1:0] mem_addr, prog_len;
  logic [20:0]   mem_wdata;
  logic [1:0]    err_code;

  program_loader #(.MAX_INSTR(MAX_INSTR), .NUM_OPS(NUM_OPS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // writes observed on the memory port, packed as {addr, wdata}
  logic [31:0] got_q[$];
  always @(negedge clk) if (mem_we === 1'b1) got_q.push_back((32'(mem_addr) << 21) | 32'(mem_wdata));

  // reference model results
  logic [31:0] exp_q[$];
  int unsigned exp_code, exp_len, exp_ncons;
  bit          exp_done;

  task automatic model(input logic [7:0] s[$]);
    int unsigned n, p;
    logic [7:0]  x, b0;
    exp_q.delete();
    exp_code = 0; exp_len = 0; exp_done = 0;
    n = s[0]; x = s[0]; p = 1;
    if (n == 0 || n > MAX_INSTR) begin
      exp_code = 1; exp_ncons = 1; return;
    end
    for (int unsigned w = 0; w < n; w++) begin
      b0 = s[p]; p++;
      if (b0 >= 8'h20 || 32'(b0 >> 1) >= NUM_OPS) begin
        exp_code = 2; exp_ncons = p; return;
      end
      exp_q.push_back((w << 21) | (32'(b0 & 8'h1F) << 16) | (32'(s[p]) << 8) | 32'(s[p+1]));
      x = x ^ b0 ^ s[p] ^ s[p+1];
      p += 2;
    end
    if (CSUM_EN) begin
      if (s[p] != x) exp_code = 3;
      p++;
    end
    exp_ncons = p;
    if (exp_code == 0) begin
      exp_done = 1; exp_len = n;
    end
  endtask

  // Presents bytes with random gaps; returns just after the edge that takes byte n-1.
  task automatic drive(input logic [7:0] s[$], input int n, input int start_at, input int unsigned gap_pct);
    int i = 0;
    int budget = 0;
    bit started = 0;
    while (i < n) begin
      @(negedge clk);
      if (start_at >= 0 && !started && i == start_at) begin start = 1'b1; started = 1; end
      else start = 1'b0;
      if ($urandom_range(99) < gap_pct) begin in_valid = 1'b0; in_data = 8'($urandom); end
      else begin in_valid = 1'b1; in_data = s[i]; end
      if (in_valid && in_ready) i++;
      budget++;
      if (budget > 3000) begin
        check("byte_accept_timeout", 32'(i), 32'(n));
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic run_load(input string tag, input logic [7:0] s[$], input int start_at, input int unsigned gap_pct);
    model(s);
    got_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, ".busy_after_start"}, 32'(busy), 1);
    check({tag, ".ready_after_start"}, 32'(in_ready), 1);
    drive(s, int'(exp_ncons), start_at, gap_pct);
    @(negedge clk);
    check({tag, ".done_edge"}, 32'(done), 32'(exp_done));
    check({tag, ".error_edge"}, 32'(error), 32'(!exp_done));
    check({tag, ".we_at_end"}, 32'(mem_we), 32'(exp_code == 0 && !CSUM_EN));
    in_valid = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, ".err_code"}, 32'(err_code), exp_code);
    check({tag, ".prog_len"}, 32'(prog_len), exp_len);
    check({tag, ".done_sticky"}, 32'(done), 32'(exp_done));
    check({tag, ".ready_idle"}, 32'(in_ready), 0);
    check({tag, ".busy_idle"}, 32'(busy), 0);
    check({tag, ".nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s.write%0d", tag, k), got_q[k], exp_q[k]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 0);
    check({tag, ".mem_we"},   32'(mem_we), 0);
    check({tag, ".busy"},     32'(busy), 0);
    check({tag, ".done"},     32'(done), 0);
    check({tag, ".error"},    32'(error), 0);
    check({tag, ".err_code"}, 32'(err_code), 0);
    check({tag, ".mem_addr"}, 32'(mem_addr), 0);
    check({tag, ".mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, ".prog_len"}, 32'(prog_len), 0);
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] s[$]);
    logic [7:0] x = '0;
    foreach (s[k]) x ^= s[k];
    return x;
  endfunction

  // random program; byte0 occasionally carries reserved bits
  task automatic gen_stream(output logic [7:0] s[$], input int unsigned n, input int unsigned bad_pct);
    s.delete();
    s.push_back(8'(n));
    for (int unsigned w = 0; w < n; w++) begin
      if ($urandom_range(99) < bad_pct) s.push_back(8'($urandom_range(32, 255)));
      else s.push_back(8'($urandom_range(0, 31)));
      s.push_back(8'($urandom));
      s.push_back(8'($urandom));
    end
    if (CSUM_EN) s.push_back(($urandom_range(3) == 0) ? ~xor_all(s) : xor_all(s));
  endtask

  logic [7:0] s[$];

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    s = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h1F, 8'hFF, 8'hFF};
    if (CSUM_EN) s.push_back(xor_all(s));
    run_load("two_words", s, -1, 0);

    s = '{8'h00};
    run_load("count_zero", s, -1, 0);
    s = '{8'h10};
    run_load("count_big", s, -1, 0);

    s = '{8'h03, 8'h01, 8'h02, 8'h03, 8'hE0, 8'h00, 8'h00, 8'h05, 8'h06, 8'h07};
    run_load("bad_word", s, -1, 0);

    gen_stream(s, 15, 0);
    run_load("n15_gaps", s, 20, 50);

    // reset after byte1 of word 1: only word 0 may reach memory
    s = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h04, 8'h56};
    got_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    drive(s, 6, -1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset.nwrites", 32'(got_q.size()), 1);
    if (got_q.size() > 0) check("midreset.write0", got_q[0], 32'h0001_2345);
    gen_stream(s, 4, 0);
    run_load("after_reset", s, -1, 20);

`ifdef LOADER_CHECKSUM_EN
    s = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
    run_load("csum_ok", s, -1, 0);
    s = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01};
    run_load("csum_bad", s, -1, 0);
`endif

    for (int r = 0; r < 10; r++) begin
      int unsigned n;
      case ($urandom_range(9))
        0:       n = 0;
        1:       n = MAX_INSTR + 1 + $urandom_range(0, 240);
        default: n = $urandom_range(1, MAX_INSTR);
      endcase
      gen_stream(s, (n > MAX_INSTR) ? 0 : n, 8);
      if (n > MAX_INSTR) s[0] = 8'(n);
      run_load($sformatf("rand%0d", r), s, int'($urandom_range(0, 6)), $urandom_range(0, 60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
